mem_burst_responder: RTL
========================

Name: mem_burst_responder

Overview:
- Simulation-side memory slave answering the CPU cache memory port: instruction-cache line refills and data-cache reads/writes.
- The caches issue requests on the io_mem_cmd channel. This block is the responder at the other end.
- It accepts commands, performs byte-masked writes into a backing word RAM, and returns read bursts on io_mem_rsp with a programmable fixed latency.
- It sits between the cache memory port and the simulation SoC.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_LOG2, 10, log2 of backing RAM depth in 32-bit words.
- LATENCY, 2, cycles from command accept to first response beat. Range 0..15.
- MAX_BURST_LOG2, 3, log2 of maximum beats per burst. Default gives 8 beats, a 32-byte line.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- io_mem_cmd_valid  in  1  command valid.
- io_mem_cmd_ready  out  1  command accepted when valid&ready.
- io_mem_cmd_payload_wr  in  1  1 = write, 0 = read.
- io_mem_cmd_payload_address  in  ADDR_WIDTH  byte address.
- io_mem_cmd_payload_data  in  32  write data.
- io_mem_cmd_payload_mask  in  4  byte enables for writes.
- io_mem_cmd_payload_size  in  3  log2 of transfer bytes.
- io_mem_rsp_valid  out  1  response beat valid. No backpressure.
- io_mem_rsp_payload_data  out  32  read data.
- io_mem_rsp_payload_error  out  1  access fault for this beat.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: io_mem_cmd_ready=0, io_mem_rsp_valid=0, rsp_data=0, rsp_error=0, state=IDLE, beat and latency counters=0.
- RAM contents are not reset.
- Word index = address[DEPTH_LOG2+1:2]. The address is out of range if any of address[ADDR_WIDTH-1:DEPTH_LOG2+2] is nonzero.
- Beats per read = 2^max(0, min(size,MAX_BURST_LOG2+2) - 2). Size 0..2 gives 1 beat; size 5 gives 8.
- The burst base address is aligned down to the burst byte size. Beats are linear, incrementing by one word. The index wraps inside the aligned block; it never crosses the block.
- FSM states: IDLE, WAIT, BURST.
- IDLE:
  - io_mem_cmd_ready=1 (registered; asserted the cycle after reset deasserts).
  - Write accept: writes the RAM in the same edge under mask. It ignores size (always single word) and produces no response. Out-of-range writes are dropped silently. FSM stays IDLE.
  - Read accept: latches base, beat count-1 and the error flag. Goes to WAIT if LATENCY>0, else BURST. ready drops to 0 the next cycle.
- WAIT: counts LATENCY-1 down to 0, then goes to BURST. ready=0.
- BURST:
  - One beat per cycle: rsp_valid=1, data=RAM[index], error=range flag.
  - An out-of-range burst returns data=0 and error=1 on every beat.
  - After the last beat, goes to IDLE. ready=1 in the cycle following the last beat.
- Latency: LATENCY=2 means cmd accepted at edge N, first rsp_valid visible after edge N+3. Each extra LATENCY adds one cycle.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Commands presented while not IDLE are held off by ready=0. They are never dropped or partially latched.
- Reset mid-burst: rsp_valid falls asynchronously. No further beats; state IDLE; RAM keeps prior writes.
- Simultaneous cmd_valid and reset release: no accept in the first cycle after release, because ready is still 0.

Optional Feature:
- Macro: MEM_BURST_RESPONDER_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 0xACE1 on reset) advances every cycle.
  - In BURST, a cycle with lfsr[0]=1 emits no beat (rsp_valid=0) and the beat index holds.
  - In IDLE, ready is additionally gated low when lfsr[1]=1.
  - Beat order and content are unchanged.
- When undefined: no LFSR logic; beats are back-to-back and IDLE ready is always 1.

Test Plan:
- Write 0xDEADBEEF to address 0x40 with mask 0xF, then read size=2 -> one beat 0xDEADBEEF, error=0, first beat LATENCY+1 cycles after the accept edge.
- Write 0x11223344 with full mask, then 0x000000AA with mask 0x1 to 0x80, then read -> 0x112233AA.
- Preload words 0x100..0x11C with values 0..7; read size=5 at address 0x10C -> 8 beats 0..7 from base 0x100, rsp_valid high 8 consecutive cycles, then ready=1 the next cycle.
- Read size=5 at address 0x0001_0000 with DEPTH_LOG2=10 -> 8 beats, data=0, error=1; a write to the same address leaves RAM unchanged.
- Assert reset after beat 3 of an 8-beat read -> rsp_valid=0 immediately, no further beats; a re-read after release returns the original RAM contents.
- Hold cmd_valid continuously with back-to-back reads -> each accept only in IDLE, no overlapping bursts; with MEM_BURST_RESPONDER_STALL_EN, beat data sequence identical to the no-stall run.

Source files
------------

// File: rtl/mem_burst_responder.sv
// mem_burst_responder
//   Simulation-side memory slave for the cache memory port. It accepts
//   commands, applies byte-masked writes to a word RAM, and returns read
//   bursts after a fixed latency.
//
//   Ports:
//     clk, reset                   clock, async active-high reset
//     io_mem_cmd_valid/ready       command handshake (ready only in IDLE)
//     io_mem_cmd_payload_wr        1 = write, 0 = read
//     io_mem_cmd_payload_address   byte address
//     io_mem_cmd_payload_data      write data
//     io_mem_cmd_payload_mask      write byte enables
//     io_mem_cmd_payload_size      log2 of transfer bytes (reads only)
//     io_mem_rsp_valid             response beat valid, no backpressure
//     io_mem_rsp_payload_data      read data
//     io_mem_rsp_payload_error     out-of-range access
//
//   Optional build macro MEM_BURST_RESPONDER_STALL_EN: an LFSR randomly
//   suppresses beats and gates ready. Beat order and content do not change.
module mem_burst_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH_LOG2     = 10,
  parameter int LATENCY        = 2,
  parameter int MAX_BURST_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_mem_cmd_valid,
  output logic                  io_mem_cmd_ready,
  input  logic                  io_mem_cmd_payload_wr,
  input  logic [ADDR_WIDTH-1:0] io_mem_cmd_payload_address,
  input  logic [31:0]           io_mem_cmd_payload_data,
  input  logic [3:0]            io_mem_cmd_payload_mask,
  input  logic [2:0]            io_mem_cmd_payload_size,
  output logic                  io_mem_rsp_valid,
  output logic [31:0]           io_mem_rsp_payload_data,
  output logic                  io_mem_rsp_payload_error
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int MAX_SIZE = MAX_BURST_LOG2 + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;

  logic [31:0]               r_mem [0:DEPTH-1];
  logic [1:0]                r_state;
  logic                      r_ready;
  logic                      r_rsp_valid;
  logic [31:0]               r_rsp_data;
  logic                      r_rsp_error;
  logic [3:0]                r_lat;
  logic [MAX_BURST_LOG2-1:0] r_beat;
  logic [MAX_BURST_LOG2-1:0] r_len_m1;
  logic [DEPTH_LOG2-1:0]     r_base;
  logic                      r_err;

  logic [DEPTH_LOG2-1:0]     w_widx;
  logic [DEPTH_LOG2-1:0]     w_base;
  logic [DEPTH_LOG2-1:0]     w_idx;
  logic [MAX_BURST_LOG2-1:0] w_len_m1;
  logic                      w_oor;
  logic                      w_cmd_acc;
  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic                      w_stall;
  logic                      w_ready_nxt;
  logic                      w_unused_addr_lsb;
  int                        w_sz_clip;
  int                        w_blog2;

  assign w_widx            = io_mem_cmd_payload_address[DEPTH_LOG2+1:2];
  assign w_oor             = |io_mem_cmd_payload_address[ADDR_WIDTH-1:DEPTH_LOG2+2];
  assign w_unused_addr_lsb = ^io_mem_cmd_payload_address[1:0];

  // Beat count: size is clipped to the max burst, sizes below a word give 1 beat.
  always_comb begin
    w_sz_clip = int'(io_mem_cmd_payload_size);
    if (w_sz_clip > MAX_SIZE) w_sz_clip = MAX_SIZE;
    w_blog2  = (w_sz_clip > 2) ? w_sz_clip - 2 : 0;
    w_len_m1 = MAX_BURST_LOG2'((1 << w_blog2) - 1);
  end

  // Base is aligned to the burst size, so OR-ing the beat number walks the
  // block linearly and can never leave it.
  assign w_base = w_widx & ~DEPTH_LOG2'(w_len_m1);
  assign w_idx  = r_base | DEPTH_LOG2'(r_beat);

  assign w_cmd_acc = io_mem_cmd_valid & r_ready & (r_state == S_IDLE);
  assign w_wr_acc  = w_cmd_acc &  io_mem_cmd_payload_wr;
  assign w_rd_acc  = w_cmd_acc & ~io_mem_cmd_payload_wr;

`ifdef MEM_BURST_RESPONDER_STALL_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  // Fibonacci LFSR, taps 16,14,13,11 (right-shift form).
  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_lfsr <= 16'hACE1;
    else       r_lfsr <= w_lfsr_nxt;
  end

  assign w_stall     = r_lfsr[0];
  // Ready is registered, so use the next LFSR value to line it up with the
  // cycle in which it is visible.
  assign w_ready_nxt = ~w_lfsr_nxt[1];
`else
  assign w_stall     = 1'b0;
  assign w_ready_nxt = 1'b1;
`endif

  // Backing RAM: not reset, so it keeps contents across a mid-burst reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !w_oor) begin
      for (int b = 0; b < 4; b++) begin
        if (io_mem_cmd_payload_mask[b])
          r_mem[w_widx][8*b +: 8] <= io_mem_cmd_payload_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 32'd0;
      r_rsp_error <= 1'b0;
      r_lat       <= 4'd0;
      r_beat      <= '0;
      r_len_m1    <= '0;
      r_base      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= w_ready_nxt;
          if (w_rd_acc) begin
            r_base   <= w_base;
            r_len_m1 <= w_len_m1;
            r_err    <= w_oor;
            r_beat   <= '0;
            r_ready  <= 1'b0;
            if (LATENCY > 0) begin
              r_state <= S_WAIT;
              r_lat   <= 4'(LATENCY - 1);
            end else begin
              r_state <= S_BURST;
            end
          end
        end
        S_WAIT: begin
          if (r_lat == 4'd0) r_state <= S_BURST;
          else               r_lat   <= r_lat - 4'd1;
        end
        S_BURST: begin
          if (!w_stall) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_err ? 32'd0 : r_mem[w_idx];
            r_rsp_error <= r_err;
            // Ready comes back from IDLE one cycle after the last beat.
            if (r_beat == r_len_m1) r_state <= S_IDLE;
            else                    r_beat  <= r_beat + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_mem_cmd_ready         = r_ready;
  assign io_mem_rsp_valid         = r_rsp_valid;
  assign io_mem_rsp_payload_data  = r_rsp_data;
  assign io_mem_rsp_payload_error = r_rsp_error;

endmodule
